serial_sub: RTL and testbench

- Parametrised multi-cycle subtractor. Computes d = a - b - bin over WIDTH bits, STEP bits per clock, with a registered borrow chain.
- Successor to the single-bit gate-level full subtractor. Trades area for latency and is generalised in width and digit size.
- Uses a start/done handshake.
- Sits in the arithmetic datapath. The sequencer that drives it also owns operand hold and result capture.

---
 rtl/serial_sub.sv | 125 ++++++++++++
 tb/tb_serial_sub.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: d = a - b - bin over WIDTH bits, STEP bits per clock, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nx;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [STEP-1:0]  dig;
    logic             br;
    logic             accept;
    logic             last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // One digit of the borrow chain; the extra top bit of the result is the borrow out.
    function automatic logic [STEP:0] sub_digit(input logic [STEP-1:0] x,
                                                input logic [STEP-1:0] y,
                                                input logic            c);
        return {1'b0, x} - {1'b0, y} - {{STEP{1'b0}}, c};
    endfunction

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (cnt == CW'(N - 1));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    always_comb begin
        {br, dig} = sub_digit(a_sr[STEP-1:0], b_sr[STEP-1:0], brw);
        res_nx    = WIDTH'({dig, res_sr} >> STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Digits enter the result from the MSB end, so after N steps the first digit sits at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bo     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            brw    <= bin;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> STEP;
            b_sr   <= b_sr >> STEP;
            res_sr <= res_nx;
            brw    <= br;
            cnt    <= cnt + CW'(1);
            if (last) begin
                d  <= res_nx;
                bo <= br;
`ifdef SERIAL_SUB_OVF_EN
                ovf <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: vector table, handshake/reset sequences, exhaustive and random runs.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       st0, st1, st2, st3;
    logic [7:0] a0, b0, a3, b3;
    logic [3:0] a1, b1, a2, b2;
    logic       bin0, bin1, bin2, bin3;
    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    logic [7:0] d0, d3;
    logic [3:0] d1, d2;
    logic       bo0, bo1, bo2, bo3;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf0, ovf1, ovf2, ovf3;
    logic       ovfv[4];
    assign ovfv[0] = ovf0;
    assign ovfv[1] = ovf1;
    assign ovfv[2] = ovf2;
    assign ovfv[3] = ovf3;
`endif

    logic       busyv[4];
    logic       donev[4];
    logic [7:0] dv[4];
    logic       bov[4];
    assign busyv[0] = busy0;  assign busyv[1] = busy1;  assign busyv[2] = busy2;  assign busyv[3] = busy3;
    assign donev[0] = done0;  assign donev[1] = done1;  assign donev[2] = done2;  assign donev[3] = done3;
    assign dv[0] = d0;  assign dv[1] = {4'h0, d1};  assign dv[2] = {4'h0, d2};  assign dv[3] = d3;
    assign bov[0] = bo0;  assign bov[1] = bo1;  assign bov[2] = bo2;  assign bov[3] = bo3;

    serial_sub #(.WIDTH(8), .STEP(1)) u0 (
        .clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .bin(bin0),
        .busy(busy0), .done(done0), .d(d0), .bo(bo0)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf0)
`endif
    );
    serial_sub #(.WIDTH(4), .STEP(2)) u1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bo(bo1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );
    serial_sub #(.WIDTH(4), .STEP(4)) u2 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .d(d2), .bo(bo2)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf2)
`endif
    );
    serial_sub #(.WIDTH(8), .STEP(4)) u3 (
        .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .d(d3), .bo(bo3)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic s, input logic [7:0] aa, input logic [7:0] bb,
                         input logic bi);
        case (u)
            0: begin st0 = s; a0 = aa;      b0 = bb;      bin0 = bi; end
            1: begin st1 = s; a1 = aa[3:0]; b1 = bb[3:0]; bin1 = bi; end
            2: begin st2 = s; a2 = aa[3:0]; b2 = bb[3:0]; bin2 = bi; end
            3: begin st3 = s; a3 = aa;      b3 = bb;      bin3 = bi; end
            default: ;
        endcase
    endtask

    // Pure arithmetic reference: {bo, d} of a - b - bin in a w-bit word.
    function automatic logic [8:0] model(input int w, input logic [7:0] aa, input logic [7:0] bb,
                                         input logic bi);
        int diff;
        logic [7:0] dd;
        diff = int'(aa) - int'(bb) - int'(bi);
        dd   = 8'((diff % (1 << w) + (1 << w)) % (1 << w));
        return {(diff < 0), dd};
    endfunction

    function automatic logic ovf_model(input int w, input logic [7:0] aa, input logic [7:0] bb,
                                       input logic [7:0] dd);
        return (aa[w-1] != bb[w-1]) && (dd[w-1] != aa[w-1]);
    endfunction

    // Launch one op, scramble the operands after acceptance, wait for done (bounded).
    task automatic run_op(input int u, input logic [7:0] aa, input logic [7:0] bb, input logic bi,
                          output logic [7:0] dd, output logic bo_o, output logic ov_o,
                          output int cyc, output int busy_cyc);
        @(negedge clk);
        drive(u, 1'b1, aa, bb, bi);
        @(negedge clk);
        drive(u, 1'b0, ~aa, ~bb, ~bi);
        cyc      = 1;
        busy_cyc = busyv[u] ? 1 : 0;
        while (!donev[u] && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busyv[u]) busy_cyc++;
        end
        dd   = dv[u];
        bo_o = bov[u];
`ifdef SERIAL_SUB_OVF_EN
        ov_o = ovfv[u];
`else
        ov_o = 1'b0;
`endif
    endtask

    initial begin
        vec_t       tbl[9];
        logic [7:0] rd;
        logic       rbo, rov;
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic       rbi;
        int         cyc, bcyc, ndone;
        int         nlist[4];

        nlist[0] = 8; nlist[1] = 2; nlist[2] = 1; nlist[3] = 2;
        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

        rst = 1'b1;
        for (int u = 0; u < 4; u++) drive(u, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_d", d0, 0);
        chk("reset_bo", bo0, 0);
        rst = 1'b0;

        // Directed vectors on the 8-bit, 1-bit-per-cycle unit
        for (int i = 0; i < 9; i++) begin
            run_op(0, tbl[i].a, tbl[i].b, tbl[i].bi, rd, rbo, rov, cyc, bcyc);
            chk($sformatf("tbl%0d_d", i), rd, tbl[i].d);
            chk($sformatf("tbl%0d_bo", i), rbo, tbl[i].bo);
            chk($sformatf("tbl%0d_latency", i), cyc, 9);
            chk($sformatf("tbl%0d_busy_cycles", i), bcyc, 8);
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), rov, tbl[i].ov);
`endif
            @(negedge clk);
            chk($sformatf("tbl%0d_done_width", i), done0, 0);
            chk($sformatf("tbl%0d_d_hold", i), d0, tbl[i].d);
        end

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        drive(0, 1'b1, 8'h05, 8'h03, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 8'h11, 8'h22, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        cyc = 0;
        while (!done0 && cyc < 40) begin @(negedge clk); cyc++; end
        chk("ignore_d", d0, 8'h02);
        chk("ignore_bo", bo0, 0);
        chk("ignore_latency", cyc, 5);

        // Back-to-back: start held in DONE, second done 9 cycles after the first
        @(negedge clk);
        drive(0, 1'b1, 8'h20, 8'h05, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        cyc = 1;
        while (!done0 && cyc < 40) begin @(negedge clk); cyc++; end
        chk("b2b_first_d", d0, 8'h1B);
        drive(0, 1'b1, 8'h01, 8'h02, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                drive(0, 1'b0, 8'hAA, 8'h55, 1'b1);
                chk("b2b_done_drop", done0, 0);
                chk("b2b_busy_no_gap", busy0, 1);
            end
            if (cyc == 5) chk("b2b_first_d_held", d0, 8'h1B);
        end while (!done0 && cyc < 40);
        chk("b2b_gap", cyc, 9);
        chk("b2b_second_d", d0, 8'hFF);
        chk("b2b_second_bo", bo0, 1);

        // Reset in the middle of RUN
        @(negedge clk);
        drive(0, 1'b1, 8'h33, 8'h11, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy0, 0);
        chk("rst_mid_done", done0, 0);
        chk("rst_mid_d", d0, 0);
        chk("rst_mid_bo", bo0, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (15) begin @(negedge clk); if (done0) ndone++; end
        chk("rst_no_done", ndone, 0);
        chk("rst_d_stays", d0, 0);
        run_op(0, 8'h33, 8'h11, 1'b0, rd, rbo, rov, cyc, bcyc);
        chk("rst_after_d", rd, 8'h22);
        chk("rst_after_latency", cyc, 9);

        // Exhaustive 4-bit, digit sizes 2 and 4
        for (int u = 1; u <= 2; u++) begin
            for (int i = 0; i < 512; i++) begin
                ra  = 8'(i & 15);
                rb  = 8'((i >> 4) & 15);
                rbi = 1'(i >> 8);
                run_op(u, ra, rb, rbi, rd, rbo, rov, cyc, bcyc);
                exp = model(4, ra, rb, rbi);
                chk($sformatf("exh_u%0d_d a=%0h b=%0h bin=%0d", u, ra, rb, rbi), rd, exp[7:0]);
                chk($sformatf("exh_u%0d_bo a=%0h b=%0h bin=%0d", u, ra, rb, rbi), rbo, exp[8]);
                chk($sformatf("exh_u%0d_latency", u), cyc, nlist[u] + 1);
`ifdef SERIAL_SUB_OVF_EN
                chk($sformatf("exh_u%0d_ovf", u), rov, ovf_model(4, ra, rb, exp[7:0]));
`endif
            end
        end

        // Random 8-bit operands on the STEP=1 and STEP=4 units
        for (int k = 0; k < 200; k++) begin
            int u;
            u   = (k % 2 == 0) ? 0 : 3;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            run_op(u, ra, rb, rbi, rd, rbo, rov, cyc, bcyc);
            exp = model(8, ra, rb, rbi);
            chk($sformatf("rnd_u%0d_d a=%0h b=%0h bin=%0d", u, ra, rb, rbi), rd, exp[7:0]);
            chk($sformatf("rnd_u%0d_bo a=%0h b=%0h bin=%0d", u, ra, rb, rbi), rbo, exp[8]);
            chk($sformatf("rnd_u%0d_latency", u), cyc, nlist[u] + 1);
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("rnd_u%0d_ovf", u), rov, ovf_model(8, ra, rb, exp[7:0]));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
